// File: rtl/ram32_fifo_ctrl_if.sv
// Push/pop handshake bundle for the RAM32 FIFO controller.
// master = producer/consumer side, slave = FIFO side.
interface ram32_fifo_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ram32_fifo_ctrl.sv
// 33-word FIFO built on the single-port RAM32 plus one output register.
// Optional status outputs (level/full/empty) with RAM32_FIFO_STATUS_EN.
module ram32_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ram32_fifo_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM32_FIFO_STATUS_EN
  ,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  logic rd_req, rd_done, push, pop;

  // Request decode; READ wins the single RAM port over a push.
  always_comb begin
    rd_done  = (state_q == READ);
    rd_req   = !out_valid_q && (cnt_q != '0) && !rd_done;
    push     = bus.in_valid && (cnt_q < FULL_CNT) && !rd_req;
    pop      = out_valid_q && bus.out_ready;
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_done);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(rd_done);
  end

  // Controller state, pointers, output register and RAM command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (rd_done) begin
        out_data_q  <= ram_rdata;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      if (rd_req) begin
        state_q <= READ;
        addr_q  <= rd_ptr_q;
        write_q <= 1'b0;
      end else if (push) begin
        state_q <= WRITE;
        addr_q  <= wr_ptr_q;
        wdata_q <= bus.in_data;
        write_q <= 1'b1;
      end else begin
        state_q <= IDLE;
        write_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (cnt_q < FULL_CNT) && !rd_req;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign ram_addr      = addr_q;
  assign ram_write     = write_q;
  assign ram_wdata     = wdata_q;

`ifdef RAM32_FIFO_STATUS_EN
  assign level = cnt_q + CNT_W'(out_valid_q);
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (level == '0);
`endif

endmodule

// File: tb/tb_ram32_fifo_ctrl.sv
// Bench for ram32_fifo_ctrl: queue-based reference model,
// RAM32 behavioural model, directed cases plus random traffic.
module tb_ram32_fifo_ctrl;

  logic clk;
  logic rst_n;
  logic [4:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
`ifdef RAM32_FIFO_STATUS_EN
  logic [5:0]  level;
  logic        full;
  logic        empty;
`endif

  ram32_fifo_ctrl_if #(.DATA_W(16)) bus ();

  ram32_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef RAM32_FIFO_STATUS_EN
    ,
    .level     (level),
    .full      (full),
    .empty     (empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM32 model: combinational read, write lands during the high phase.
  logic [15:0] mem [32];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    #2;
    if (ram_write) mem[ram_addr] = ram_wdata;
  end

  logic        iv;
  logic [15:0] id;
  logic        ordy;
  assign bus.in_valid  = iv;
  assign bus.in_data   = id;
  assign bus.out_ready = ordy;

  int errs = 0;
  int checks = 0;

  // Reference model: every word held by the FIFO, head first.
  logic [15:0] fifo [$];
  logic [15:0] got [$];
  bit          mv;
  logic [15:0] md;
  bit          busy;
  int          wr_total;
  int          rd_total;
  logic [4:0]  e_addr;
  bit          e_we;
  logic [15:0] e_wd;
  bit          wrapped;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ramcnt();
    return fifo.size() - (mv ? 1 : 0);
  endfunction

  function automatic bit rdreq();
    return !mv && ramcnt() != 0 && !busy;
  endfunction

  function automatic bit irdy();
    return ramcnt() < 32 && !rdreq();
  endfunction

  task automatic model_reset();
    fifo.delete();
    mv = 0; md = '0; busy = 0;
    wr_total = 0; rd_total = 0;
    e_addr = '0; e_we = 0; e_wd = '0;
  endtask

  task automatic compare();
    chk("in_ready", 32'(bus.in_ready), 32'(irdy()));
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    chk("out_data", 32'(bus.out_data), 32'(md));
    chk("ram_write", 32'(ram_write), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
`ifdef RAM32_FIFO_STATUS_EN
    chk("level", 32'(level), 32'(fifo.size()));
    chk("full", 32'(full), 32'(ramcnt() == 32));
    chk("empty", 32'(empty), 32'(fifo.size() == 0));
`endif
  endtask

  // One clock: check at negedge, advance model on the rising edge.
  task automatic cyc();
    bit acc, popd, rq;
    logic [15:0] d;
    logic [4:0] prev;
    compare();
    acc  = iv && irdy();
    popd = mv && ordy;
    rq   = rdreq();
    d    = id;
    prev = ram_addr;
    @(posedge clk);
    if (busy) begin
      mv = 1; md = fifo[0]; rd_total++;
    end else if (popd) begin
      got.push_back(md);
      void'(fifo.pop_front());
      mv = 0;
    end
    if (rq) begin
      busy = 1; e_addr = 5'(rd_total); e_we = 0;
    end else if (acc) begin
      busy = 0; e_addr = 5'(wr_total); e_we = 1; e_wd = d;
      wr_total++;
      fifo.push_back(d);
    end else begin
      busy = 0; e_we = 0;
    end
    @(negedge clk);
    if (prev == 5'd31 && ram_addr == 5'd0) wrapped = 1;
  endtask

  task automatic fill(int n, logic [15:0] base);
    int k = 0;
    int b = 0;
    ordy = 0;
    while (k < n && b < 500) begin
      bit a;
      iv = 1; id = base + 16'(k);
      a = irdy();
      cyc();
      if (a) k++;
      b++;
    end
    iv = 0;
    if (b >= 500) chk("fill_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    iv = 0; ordy = 1;
    while ((fifo.size() != 0 || busy) && n < 300) begin
      cyc();
      n++;
    end
    ordy = 0;
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    iv = 0; id = '0; ordy = 0; wrapped = 0;
    model_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_ram_write", 32'(ram_write), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);

    // Reset while a WRITE is on the RAM port.
    iv = 1; id = 16'h1234;
    cyc();
    iv = 0;
    chk("t1_write_on", 32'(ram_write), 1);
    rst_n = 0;
    #1;
    chk("t1_write_drop", 32'(ram_write), 0);
    chk("t1_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    chk("t1_in_ready", 32'(bus.in_ready), 1);
    repeat (4) cyc();

    // Single push into an empty FIFO.
    iv = 1; id = 16'hA5A5; ordy = 0;
    cyc();
    iv = 0;
    chk("t2_we1", 32'(ram_write), 1);
    chk("t2_addr1", 32'(ram_addr), 0);
    cyc();
    chk("t2_we2", 32'(ram_write), 0);
    chk("t2_addr2", 32'(ram_addr), 0);
    cyc();
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_data", 32'(bus.out_data), 32'h0000A5A5);
    drain();

    // Fill to 33 words, then the full-boundary pop.
    got.delete();
    fill(33, 16'h0000);
    iv = 1;
    cyc();
    chk("t3_full_ready", 32'(bus.in_ready), 0);
`ifdef RAM32_FIFO_STATUS_EN
    chk("t3_level", 32'(level), 33);
`endif
    iv = 0; ordy = 1;
    cyc();
    ordy = 0; iv = 1; id = 16'hBEEF;
    chk("t6_ready_rdreq", 32'(bus.in_ready), 0);
    cyc();
    chk("t6_read_issue", 32'(ram_write), 0);
    chk("t6_ready_read", 32'(bus.in_ready), 0);
    iv = 0;
    cyc();
    chk("t6_ready_back", 32'(bus.in_ready), 1);
    drain();
    chk("t3_count", got.size(), 33);
    for (int i = 0; i < got.size() && i < 33; i++)
      chk("t3_order", 32'(got[i]), i);

    // READ takes priority over a waiting push.
    fill(4, 16'h0050);
    repeat (3) cyc();
    ordy = 1;
    cyc();
    ordy = 0; iv = 1; id = 16'h0077;
    chk("t5_valid0", 32'(bus.out_valid), 0);
    chk("t5_ready0", 32'(bus.in_ready), 0);
    cyc();
    chk("t5_read", 32'(ram_write), 0);
    chk("t5_ready1", 32'(bus.in_ready), 1);
    cyc();
    iv = 0;
    chk("t5_write", 32'(ram_write), 1);
    chk("t5_wdata", 32'(ram_wdata), 32'h77);
    drain();

    // 100-word stream with random consumer stalls.
    got.delete();
    wrapped = 0;
    begin
      int k = 0;
      int n = 0;
      while ((k < 100 || fifo.size() != 0 || busy) && n < 3000) begin
        bit a;
        iv = (k < 100) && ($urandom_range(0, 3) != 0);
        id = 16'h1000 + 16'(k);
        ordy = $urandom_range(0, 1);
        a = iv && irdy();
        cyc();
        if (a) k++;
        n++;
      end
      if (n >= 3000) chk("t4_timeout", 0, 1);
    end
    iv = 0; ordy = 0;
    chk("t4_count", got.size(), 100);
    chk("t4_wrap", 32'(wrapped), 1);
    for (int i = 0; i < got.size() && i < 100; i++)
      chk("t4_order", 32'(got[i]), 32'h1000 + i);

    // Random soak with long stalls to hit full repeatedly.
    for (int i = 0; i < 800; i++) begin
      iv = ($urandom_range(0, 3) != 0);
      id = 16'($urandom);
      ordy = ((i % 200) < 70) ? 1'b0 : 1'($urandom_range(0, 1));
      cyc();
    end
    drain();
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
